// File: rtl/burst_mem_pkg.sv
// Shared types and helpers for the burst memory responder: FSM states,
// beat geometry helpers and the read-FIFO entry layout.
package burst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } burst_state_t;

    // Beat width carried by the read FIFO entry; the top's data_width must match it.
    localparam int BEAT_WIDTH = 32;

    typedef struct packed {
        logic [BEAT_WIDTH-1:0] data;
        logic                  last;
    } fifo_entry_t;

    function automatic int bytes_per_beat(input int dw);
        return dw / 8;
    endfunction

    function automatic int log2_bpb(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/burst_mem_responder_fifo.sv
// Two-entry registered FIFO holding read beats and their last tag, so the
// array can keep issuing while the consumer stalls.
module burst_rd_skid_fifo
    import burst_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  fifo_entry_t i_push_entry,
    input  logic        i_pop,
    output logic [1:0]  o_count,
    output fifo_entry_t o_head
);

    fifo_entry_t [1:0] w_slot;
    logic              r_wr_idx;
    logic              r_rd_idx;
    logic [1:0]        r_count;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            fifo_entry_t r_entry;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (i_push && (r_wr_idx == 1'(gi))) begin
                    r_entry <= i_push_entry;
                end
            end
            assign w_slot[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_idx <= ~r_wr_idx;
            if (i_pop)  r_rd_idx <= ~r_rd_idx;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = w_slot[r_rd_idx];

endmodule

// File: rtl/burst_mem_responder.sv
// Backing-memory responder: services one read or write burst at a time from a
// single-port word array, alternating fairly between the two request types.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = BEAT_WIDTH,
    parameter int mem_depth  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    output logic                  wr_gnt,
    input  logic [15:0]           wr_len,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  wr_done,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    input  logic [15:0]           rd_len,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_done,
    output logic                  err
);

    localparam int          BPB      = bytes_per_beat(data_width);
    localparam int          LOG2_BPB = log2_bpb(data_width);
    localparam int          MEM_AW   = $clog2(mem_depth);
    localparam logic [15:0] BPB16    = 16'(BPB);
    localparam logic [15:0] BPB_MASK = 16'(BPB - 1);

    burst_state_t r_state;
    burst_state_t w_state_next;

    logic [data_width-1:0] r_mem [mem_depth];
    logic [data_width-1:0] r_mem_rdata;

    logic [MEM_AW-1:0] r_ptr;
    logic [15:0]       r_beats;
    logic [15:0]       r_cnt;
    logic [15:0]       r_issued;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_err;
    logic              r_last_rd;

    logic              w_wr_wins;
    logic              w_rd_wins;
    logic              w_wr_hs;
    logic              w_rd_hs;
    logic [15:0]       w_req_len;
    logic [MEM_AW-1:0] w_req_ptr;
    logic [15:0]       w_req_beats_raw;
    logic [15:0]       w_req_beats;
    logic              w_len_bad;
    logic              w_wr_beat;
    logic [16:0]       w_cnt_next;
    logic              w_wr_err;
    logic [15:0]       w_issued_next;
    logic              w_pop;
    logic              w_issue;
    logic [1:0]        w_fifo_count;
    fifo_entry_t       w_head;
    fifo_entry_t       w_push_entry;

    // Ties go to whichever type was not served last.
    assign w_wr_wins = wr_req && (!rd_req || r_last_rd);
    assign w_rd_wins = rd_req && !w_wr_wins;
    assign w_wr_hs   = wr_req && wr_gnt;
    assign w_rd_hs   = rd_req && rd_gnt;

    assign w_req_len       = w_wr_hs ? wr_len : rd_len;
    assign w_req_ptr       = w_wr_hs ? MEM_AW'(wr_addr >> LOG2_BPB) : MEM_AW'(rd_addr >> LOG2_BPB);
    assign w_req_beats_raw = w_req_len >> LOG2_BPB;
    assign w_req_beats     = (w_req_beats_raw == 16'd0) ? 16'd1 : w_req_beats_raw;
    assign w_len_bad       = ((w_req_len & BPB_MASK) != 16'd0) || (w_req_len < BPB16);

    assign w_wr_beat  = wr_valid && wr_ready;
    assign w_cnt_next = {1'b0, r_cnt} + 17'd1;
    assign w_wr_err   = wr_last ? (w_cnt_next != {1'b0, r_beats})
                                : (w_cnt_next >  {1'b0, r_beats});

    // Issue only when the FIFO is guaranteed a free slot for the returning word.
    assign w_pop         = rd_valid && rd_ready;
    assign w_issued_next = r_issued + 16'd1;
    assign w_issue       = (r_state == RD_DATA) && (r_issued < r_beats) &&
                           (({1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        wr_ready     = 1'b0;
        wr_done      = 1'b0;
        case (r_state)
            IDLE: begin
                wr_gnt = w_wr_wins;
                rd_gnt = w_rd_wins;
                if (w_wr_wins)      w_state_next = WR_DATA;
                else if (w_rd_wins) w_state_next = RD_DATA;
            end
            WR_DATA: begin
                wr_ready = 1'b1;
                if (wr_valid && wr_last) w_state_next = WR_RESP;
            end
            WR_RESP: begin
                wr_done      = 1'b1;
                w_state_next = IDLE;
            end
            RD_DATA: begin
                if (w_pop && w_head.last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr           <= '0;
            r_beats         <= 16'd0;
            r_cnt           <= 16'd0;
            r_issued        <= 16'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_err           <= 1'b0;
            r_last_rd       <= 1'b1;
        end else begin
            if (w_wr_hs || w_rd_hs) begin
                r_ptr     <= w_req_ptr;
                r_beats   <= w_req_beats;
                r_cnt     <= 16'd0;
                r_issued  <= 16'd0;
                r_last_rd <= w_rd_hs;
                if (w_len_bad) r_err <= 1'b1;
            end else begin
                if (w_wr_beat) begin
                    r_ptr <= r_ptr + 1'b1;
                    r_cnt <= r_cnt + 16'd1;
                    if (w_wr_err) r_err <= 1'b1;
                end
                if (w_issue) begin
                    r_ptr    <= r_ptr + 1'b1;
                    r_issued <= w_issued_next;
                end
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (w_issued_next == r_beats);
        end
    end

    // Single shared port: writes and reads never overlap since bursts are exclusive.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[r_ptr] <= wr_data;
        end else if (w_issue) begin
            r_mem_rdata <= r_mem[r_ptr];
        end
    end

    assign w_push_entry = '{data: r_mem_rdata, last: r_inflight_last};

    burst_rd_skid_fifo u_rd_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (r_inflight),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_fifo_count),
        .o_head       (w_head)
    );

    assign rd_valid = (w_fifo_count != 2'd0);
    assign rd_data  = w_head.data;
    assign rd_done  = rd_valid && w_head.last;
    assign err      = r_err;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized scoreboard bench for burst_mem_responder: a word-array model
// predicts read beats, and a negedge monitor checks every beat the DUT presents.
module tb_burst_mem_responder;

    localparam int D = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0, wr_valid = 1'b0, wr_last = 1'b0;
    logic [15:0] wr_len = '0, rd_len = '0;
    logic [31:0] wr_addr = '0, rd_addr = '0, wr_data = '0;
    logic        rd_req = 1'b0, rd_ready = 1'b0;
    logic        wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done, err;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    burst_mem_responder dut (
        .clk      (clk),      .rst_n    (rst_n),
        .wr_req   (wr_req),   .wr_gnt   (wr_gnt),
        .wr_len   (wr_len),   .wr_addr  (wr_addr),
        .wr_data  (wr_data),  .wr_valid (wr_valid),
        .wr_last  (wr_last),  .wr_ready (wr_ready),
        .wr_done  (wr_done),
        .rd_req   (rd_req),   .rd_gnt   (rd_gnt),
        .rd_len   (rd_len),   .rd_addr  (rd_addr),
        .rd_data  (rd_data),  .rd_valid (rd_valid),
        .rd_ready (rd_ready), .rd_done  (rd_done),
        .err      (err)
    );

    typedef struct {
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [D];
    bit          exp_err = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          beats_seen = 0;
    bit          stall_pending = 1'b0;
    logic [31:0] stall_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops one expected beat per accepted read handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (wr_gnt || rd_gnt) chk("single_grant", 64'(wr_gnt && rd_gnt), 64'd0);
            if (rd_valid) begin
                if (stall_pending) chk("rd_data_stable", rd_data, stall_data);
                if (rd_ready) begin
                    stall_pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rd_unexpected_beat: got data 0x%0h, required no beat", rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", rd_data, e.data);
                        chk("rd_done", rd_done, e.last);
                        beats_seen++;
                    end
                end else begin
                    stall_pending = 1'b1;
                    stall_data    = rd_data;
                end
            end else begin
                if (stall_pending) chk("rd_valid_held", rd_valid, 1'b1);
                stall_pending = 1'b0;
                chk("rd_done_no_valid", rd_done, 1'b0);
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_gnt"},   wr_gnt,   0);
        chk({tag, "_rd_gnt"},   rd_gnt,   0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_wr_done"},  wr_done,  0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_done"},  rd_done,  0);
        chk({tag, "_rd_data"},  rd_data,  0);
        chk({tag, "_err"},      err,      0);
    endtask

    task automatic wait_grant(input bit want_wr, input bit want_rd, output bit got_wr);
        int t;
        @(posedge clk);
        #1;
        wr_req = want_wr;
        rd_req = want_rd;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (wr_gnt || rd_gnt) break;
        end
        chk("grant_same_cycle", 64'(t), 64'd0);
        got_wr = wr_gnt;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    function automatic bit ready_val(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // dmode 0: data = beat index, no gaps; dmode 1: random data with random valid gaps.
    task automatic write_burst(input int unsigned addr, input int len, input int nbeats,
                               input int dmode, input bit both);
        int          ptr = int'((addr / 4) % D);
        int          nom = (len / 4 < 1) ? 1 : len / 4;
        bit          got_wr;
        logic [31:0] d;
        wr_addr = addr; wr_len = 16'(len);
        rd_addr = addr; rd_len = 16'(len);
        wait_grant(1'b1, both, got_wr);
        chk("wr_grant", got_wr, 1);
        if ((len % 4 != 0) || (len < 4) || (nbeats != nom)) exp_err = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            if (dmode == 1 && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            d        = (dmode == 0) ? 32'(i) : $urandom;
            wr_data  = d;
            wr_valid = 1'b1;
            wr_last  = (i == nbeats - 1);
            @(negedge clk);
            chk("wr_ready", wr_ready, 1);
            chk("wr_done_early", wr_done, 0);
            @(posedge clk);
            #1;
            model_mem[(ptr + i) % D] = d;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clk);
        chk("wr_done_pulse", wr_done, 1);
        @(negedge clk);
        chk("wr_done_once", wr_done, 0);
        chk("wr_err", err, exp_err);
    endtask

    task automatic read_burst(input int unsigned addr, input int len, input int rmode,
                              input bit both, input int abort_after);
        int ptr   = int'((addr / 4) % D);
        int beats = (len / 4 < 1) ? 1 : len / 4;
        int base;
        bit got_wr;
        bit done_ok = 1'b0;
        wr_addr = addr; wr_len = 16'(len);
        rd_addr = addr; rd_len = 16'(len);
        wait_grant(both, 1'b1, got_wr);
        chk("rd_grant", got_wr, 0);
        if ((len % 4 != 0) || (len < 4)) exp_err = 1'b1;
        for (int i = 0; i < beats; i++) exp_q.push_back('{model_mem[(ptr + i) % D], i == beats - 1});
        base     = beats_seen;
        rd_ready = ready_val(rmode, 0);
        for (int c = 1; c <= beats * 8 + 20; c++) begin
            @(negedge clk);
            if (c <= 3) chk("rd_first_valid", rd_valid, c == 3);
            @(posedge clk);
            if (abort_after > 0 && beats_seen - base >= abort_after) begin
                #1;
                rst_n = 1'b0;
                exp_q.delete();
                #1;
                chk_outputs_zero("mid_reset");
                exp_err  = 1'b0;
                rd_ready = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (exp_q.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
            #1;
            rd_ready = ready_val(rmode, c);
        end
        if (!done_ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_timeout: got %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        #1;
        rd_ready = 1'b0;
        @(negedge clk);
        chk("rd_idle_after_last", rd_valid, 0);
        chk("rd_err", err, exp_err);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Both requests after reset: write wins, then read wins the next tie.
        write_burst(32'h100, 128, 32, 0, 1'b1);
        read_burst(32'h100, 128, 0, 1'b1, 0);
        read_burst(32'h100, 128, 1, 1'b0, 0);

        write_burst((D - 4) * 4, 32, 8, 1, 1'b0);
        read_burst((D - 4) * 4, 32, 2, 1'b0, 0);
        read_burst(0, 16, 0, 1'b0, 0);

        write_burst(32'h400, 64, 16, 1, 1'b0);
        write_burst(32'h400, 64, 5, 1, 1'b0);
        read_burst(32'h400, 64, 2, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            int unsigned a  = $urandom_range(0, D - 1) * 4;
            int          nb = $urandom_range(1, 8);
            write_burst(a, nb * 4, nb, 1, 1'b0);
            read_burst(a, nb * 4, 2, 1'b0, 0);
        end

        read_burst(32'h100, 64, 0, 1'b0, 3);
        read_burst(32'h100, 64, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Memory-side responder for the cache's burst read/write interface. It accepts line-fill read bursts and write-back bursts from the fetch controller's `wr_*`/`rd_*` ports and services them from an internal single-port word array. It serves as the backing-memory model for cache bring-up and as the template for the later DRAM-side bridge. One burst is active at a time, and read and write requests are arbitrated fairly.

## Interface
- `addr_width`, 32, byte-address width of `wr_addr`/`rd_addr`
- `data_width`, 32, beat width (power of two, ≥8); bytes per beat `bpb = data_width/8`
- `mem_depth`, 1024, number of words in the array (power of two)

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_req` in 1, `wr_gnt` out 1: write-burst request/grant.
- `wr_len` in 16, `wr_addr` in `addr_width`: burst byte length and start byte address.
- `wr_data` in `data_width`, `wr_valid` in 1, `wr_last` in 1, `wr_ready` out 1: write beats.
- `wr_done` out 1: one-cycle write-completion pulse.
- `rd_req` in 1, `rd_gnt` out 1, `rd_len` in 16, `rd_addr` in `addr_width`: read-burst request.
- `rd_data` out `data_width`, `rd_valid` out 1, `rd_ready` in 1: read beats.
- `rd_done` out 1: high together with the final read beat.
- `err` out 1: sticky protocol-error flag, cleared only by reset.

## Operation
- FSM states are `IDLE`, `WR_DATA`, `WR_RESP` and `RD_DATA`.
- **Grant.** `wr_gnt`/`rd_gnt` are combinational and asserted only in `IDLE`, to the arbitration winner.
  - If exactly one request is present, that request wins.
  - If both are present, the type not served last wins. Reset value of the last-served flag = read.
- **Handshake latch.** On `req && gnt`, latch the start word pointer `ptr = (addr >> log2(bpb)) mod mem_depth` and `beats = wr_len/bpb` (or `rd_len/bpb`).
  - If `len` is not a multiple of `bpb`, or `len < bpb`, set `err`; `beats` is then forced to ≥1 (floor, minimum 1).
- **Write burst (`WR_DATA`).**
  - `wr_ready` = 1 for the whole state.
  - Each `wr_valid && wr_ready` beat writes `mem[ptr]`, then `ptr++` (wraps at `mem_depth`) and `cnt++`.
  - The burst ends on the handshake of the beat with `wr_last`; the FSM then moves to `WR_RESP`.
  - If `wr_last` arrives on a beat other than beat `beats`, set `err`. Beats past `beats` without `wr_last` set `err` and are still written.
- **`WR_RESP`.** `wr_done` = 1 for exactly one cycle, then `IDLE`.
- **Read burst (`RD_DATA`).**
  - An array read is issued while `issued < beats` and `fifo_cnt − pop + inflight < 2`, where `pop = rd_valid && rd_ready`.
  - Read data is captured, one cycle later, into a 2-entry FIFO together with a last tag.
  - `rd_valid` = FIFO not empty, and `rd_data` = FIFO head.
  - `rd_done` = `rd_valid && head.last`.
  - The FSM returns to `IDLE` on the handshake of the last beat.
- `rd_data` is held stable while `rd_valid && !rd_ready`.
- Array contents are not reset.

## Timing
- Reset values: `wr_gnt`, `rd_gnt`, `wr_ready`, `wr_done`, `rd_valid` and `rd_done` = 0; `rd_data` = 0; `err` = 0.
- Reset drives the FSM to `IDLE`, flushes the FIFO and drops in-flight reads.
- Reset mid-burst abandons the burst; no `done` is issued.
- Grant is given in the same cycle as the request when the FSM is in `IDLE`.
- The FSM enters the burst state on the cycle after the handshake.
- Write latency:
  - The first `wr_ready` is 1 cycle after the handshake.
  - `wr_done` is 1 cycle after the last-beat handshake.
  - A new grant is possible 2 cycles after the last beat.
- Read latency and throughput:
  - The first `rd_valid` is 3 cycles after the handshake (issue at H+1, capture at H+2, visible at H+3).
  - With `rd_ready` held at 1, there is one beat per cycle with no bubbles.
- Wrap-around: the pointer wraps at `mem_depth`, so `mem_depth−1` is followed by 0, for both directions.
- Simultaneous requests in `IDLE`: exactly one grant is issued, never both.

## Structure
- Package `burst_mem_pkg` contains:
  - the state enum `burst_state_t`;
  - a function for `bpb` and its log2;
  - the FIFO entry struct `{data, last}`.
- Sub-module `burst_rd_skid_fifo`: 2-entry registered FIFO with push, pop, count, head and last tag.
- The array is a plain `logic` memory inferred as a 1-cycle synchronous-read RAM.

## Test plan
- **Write/read round trip.** Write 32 beats to `0x100` (`wr_len` = 128), data = index. Then read 32 beats from `0x100`.
  - Required: `wr_done` pulses once, 1 cycle after the last beat.
  - Required: the read returns 0..31, `rd_done` is high only on beat 31, and `err` = 0.
- **Read backpressure.** `rd_ready` follows the pattern 1,0,0,1 during the read.
  - Required: `rd_data` is stable while stalled, no beat is lost or duplicated, and the order is preserved.
- **Simultaneous requests.** Assert `wr_req` and `rd_req` together, twice in a row.
  - Required: the first grant is write (last-served reset value = read); the second grant is read.
- **Wrap-around.** Write 8 beats starting at word `mem_depth−4`.
  - Required: words `mem_depth−4..mem_depth−1` and 0..3 are written; readback from the same address matches.
- **Early `wr_last`.** `wr_len` = 64 with `wr_last` on beat 5.
  - Required: `err` = 1, `wr_done` pulses, and only 5 words are modified.
- **Reset mid-read.** Assert `rst_n` = 0 after beat 3 of a 16-beat read.
  - Required: all outputs are 0 and the FSM is in `IDLE`.
  - Required: a subsequent read completes normally.
